// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_sched_pkg;

   localparam int NREQ      = 2;
   localparam int CNT_W_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RUN   = 2'd2,
      CHECK = 2'd3
   } state_t;

endpackage

// File: rtl/counter_scheduler_if.sv
// Requester-side bundle of the counter scheduler: requests, lengths, grant/done/status.
// Latency: n/a (wires only).
// Backpressure: none; req is a level, sampled by the scheduler only when idle.
// Ports: master = requester side (drives req/len0/len1/err_clr), slave = scheduler side.
interface counter_scheduler_if
   import counter_sched_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic [NREQ-1:0]  req;
   logic [CNT_W-1:0] len0;
   logic [CNT_W-1:0] len1;
   logic             err_clr;
   logic [NREQ-1:0]  gnt;
   logic [NREQ-1:0]  done;
   logic             busy;
   logic [CNT_W-1:0] start_val;
   logic             err;

   modport master (
      output req, len0, len1, err_clr,
      input  gnt, done, busy, start_val, err
   );

   modport slave (
      input  req, len0, len1, err_clr,
      output gnt, done, busy, start_val, err
   );
endinterface

// File: rtl/counter.sv
// 3-bit toggle-enabled up counter: increments on each rising clk edge while T is high.
// Latency: one edge from T to the new A2..A0 value.
// Backpressure: none. Ports: clk, T in; A0..A2 out (A2 = MSB). No reset: value persists.
module counter (
   input  logic clk,
   input  logic T,
   output logic A0,
   output logic A1,
   output logic A2
);
   logic [2:0] cnt;

   always_ff @(posedge clk) begin
      if (T) begin
         cnt <= cnt + 3'd1;
      end
   end

   assign {A2, A1, A0} = cnt;
endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: single requester wins outright, on a tie the pointer holder wins.
// Latency: combinational; pointer update is applied by the caller's register.
// Backpressure: none. Ports: req, ptr, advance in; win (one-hot), ptr_nxt out.
module rr_arbiter2
   import counter_sched_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic            ptr,
   input  logic            advance,
   output logic [NREQ-1:0] win,
   output logic            ptr_nxt
);
   always_comb begin
      win     = 2'b00;
      ptr_nxt = ptr;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = ptr ? 2'b10 : 2'b01;
         default: win = 2'b00;
      endcase
      // Priority passes to whichever requester did not win this grant.
      if (advance && (req != 2'b00)) begin
         ptr_nxt = ~win[1];
      end
   end
endmodule

// File: rtl/counter_scheduler.sv
// Shares one toggle counter between two requesters: RR grant, run len+1 ticks, verify end value.
// Latency: gnt one edge after req seen in IDLE; done pulses in the cycle after edge k+len+2.
// Backpressure: none; req is ignored while busy, a still-high req re-arbitrates after one idle cycle.
// Ports: clk, rst_n; bus (slave modport: req/len0/len1/err_clr in, gnt/done/busy/start_val/err out);
//        T out to the counter, A0..A2 in from the counter.
module counter_scheduler
   import counter_sched_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter bit RR_INIT = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   counter_scheduler_if.slave bus,
   output logic               T,
   input  logic               A0,
   input  logic               A1,
   input  logic               A2
);
   state_t           state;
   state_t           state_nxt;
   logic             ptr;
   logic             ptr_nxt;
   logic [NREQ-1:0]  win;
   logic             start_run;
   logic [CNT_W-1:0] rem;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] cur_val;
   logic [CNT_W-1:0] exp_val;
   logic [NREQ-1:0]  gnt_q;
   logic [NREQ-1:0]  done_q;
   logic             busy_q;
   logic             err_q;
   logic [CNT_W-1:0] start_q;

   assign cur_val   = {A2, A1, A0};
   // Sum wraps at counter width, so a full 8-tick run expects the start value again.
   assign exp_val   = start_q + len_q + CNT_W'(1);
   assign start_run = (state == IDLE) && (bus.req != '0);

   rr_arbiter2 u_arb (
      .req     (bus.req),
      .ptr     (ptr),
      .advance (start_run),
      .win     (win),
      .ptr_nxt (ptr_nxt)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.req != '0) state_nxt = GRANT;
         GRANT:   state_nxt = RUN;
         RUN:     if (rem == '0) state_nxt = CHECK;
         CHECK:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= RR_INIT;
         T       <= 1'b0;
         gnt_q   <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         start_q <= '0;
         rem     <= '0;
         len_q   <= '0;
      end else begin
         state  <= state_nxt;
         ptr    <= ptr_nxt;
         // T follows the registered state so it is high for exactly the RUN cycles.
         T      <= (state_nxt == RUN);
         busy_q <= (state_nxt != IDLE);
         done_q <= ((state == RUN) && (rem == '0)) ? gnt_q : '0;

         // Capture at the grant edge: counter is still idle, so this is the true start value.
         if (start_run) begin
            gnt_q   <= win;
            start_q <= cur_val;
            rem     <= win[1] ? bus.len1 : bus.len0;
            len_q   <= win[1] ? bus.len1 : bus.len0;
         end else if ((state == RUN) && (rem != '0)) begin
            rem <= rem - CNT_W'(1);
         end

         if (state == CHECK) begin
            gnt_q <= '0;
         end

         // A mismatch outranks a simultaneous clear.
         if ((state == CHECK) && (cur_val != exp_val)) begin
            err_q <= 1'b1;
         end else if (bus.err_clr) begin
            err_q <= 1'b0;
         end
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.start_val = start_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler driving the real counter, with a reference model of grants and timing.
// Latency: checks grant, done cycle, tick count and end value per run.
// Backpressure: n/a.
module tb_counter_scheduler;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic glitch = 1'b0;
   logic T;
   logic A0, A1, A2;
   logic cnt_t;

   counter_scheduler_if #(.CNT_W(3)) bus ();

   counter_scheduler #(.CNT_W(3), .RR_INIT(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .T     (T),
      .A0    (A0),
      .A1    (A1),
      .A2    (A2)
   );

   assign cnt_t = T | glitch;

   counter u_cnt (
      .clk (clk),
      .T   (cnt_t),
      .A0  (A0),
      .A1  (A1),
      .A2  (A2)
   );

   always #10 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int ptr_m = 0;
   int cnt_m = 0;
   int err_m = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic do_reset();
      bus.req = 2'b00;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      ptr_m   = 0;
      err_m   = 0;
      @(negedge clk);
   endtask

   // Setup only: step the idle counter to a known value using the bench's glitch path.
   task automatic set_counter(input int target);
      int n;
      logic [2:0] a;
      a = {A2, A1, A0};
      n = (target - int'(a)) & 7;
      if (n > 0) begin
         glitch = 1'b1;
         repeat (n) @(negedge clk);
         glitch = 1'b0;
      end
      cnt_m = target & 7;
   endtask

   // One complete request/run/check; called at a negedge while the scheduler is idle.
   task automatic run_one(input logic [1:0] rq, input logic [2:0] l0, input logic [2:0] l1,
                          input bit hold, input bit g, input string tag);
      int w, len, st, tcnt, done_at, exp_err;
      logic [1:0] wv;
      logic [2:0] exp_a;
      if (rq == 2'b01)      w = 0;
      else if (rq == 2'b10) w = 1;
      else                  w = ptr_m;
      ptr_m   = 1 - w;
      len     = (w == 1) ? int'(l1) : int'(l0);
      st      = cnt_m;
      wv      = 2'(1 << w);
      exp_a   = 3'((st + len + 1) & 7);
      exp_err = (err_m != 0 || g) ? 1 : 0;
      bus.req  = rq;
      bus.len0 = l0;
      bus.len1 = l1;
      tcnt     = 0;
      done_at  = 0;
      for (int c = 1; c <= len + 4; c++) begin
         @(negedge clk);
         if (T === 1'b1) tcnt++;
         if (bus.done !== 2'b00 && done_at == 0) begin
            done_at = c;
            chk({tag, "_done_val"}, 32'(bus.done), 32'(wv));
         end
         if (c == 1) begin
            chk({tag, "_gnt"}, 32'(bus.gnt), 32'(wv));
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_start_val"}, 32'(bus.start_val), 32'(st));
            if (g) glitch = 1'b1;
         end
         if (c == 2) begin
            glitch = 1'b0;
            if (!hold) bus.req = 2'b00;
            bus.len0 = ~l0;
            bus.len1 = ~l1;
         end
         if (c == len + 3) begin
            chk({tag, "_gnt_chk"}, 32'(bus.gnt), 32'(wv));
            if (!g) chk({tag, "_end_val"}, 32'({A2, A1, A0}), 32'(exp_a));
         end
         if (c == len + 4) begin
            chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
            chk({tag, "_idle_gnt"}, 32'(bus.gnt), 32'd0);
            chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
         end
      end
      chk({tag, "_done_cycle"}, 32'(done_at), 32'(len + 3));
      chk({tag, "_ticks"}, 32'(tcnt), 32'(len + 1));
      cnt_m = (st + len + 1 + (g ? 1 : 0)) & 7;
      err_m = exp_err;
   endtask

   initial begin
      bus.req     = 2'b00;
      bus.len0    = 3'd0;
      bus.len1    = 3'd0;
      bus.err_clr = 1'b0;
      rst_n       = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_T", 32'(T), 32'd0);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_start_val", 32'(bus.start_val), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single requester, len 2 from 0.
      set_counter(0);
      run_one(2'b01, 3'd2, 3'd5, 1'b0, 1'b0, "basic");

      // Simultaneous requests held: grants alternate starting with requester 0.
      do_reset();
      set_counter(0);
      run_one(2'b11, 3'd1, 3'd3, 1'b1, 1'b0, "alt0");
      run_one(2'b11, 3'd1, 3'd3, 1'b1, 1'b0, "alt1");
      run_one(2'b11, 3'd1, 3'd3, 1'b0, 1'b0, "alt2");
      @(negedge clk);
      chk("no_regrant", 32'(bus.busy), 32'd0);

      // Full wrap: 8 ticks from 5 returns to 5.
      set_counter(5);
      run_one(2'b10, 3'd4, 3'd7, 1'b0, 1'b0, "wrap");

      // Injected extra tick, stickiness, then clear.
      run_one(2'b01, 3'($urandom_range(0, 7)), 3'd1, 1'b0, 1'b1, "glitch");
      run_one(2'b10, 3'd0, 3'($urandom_range(0, 7)), 1'b0, 1'b0, "sticky");
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      @(negedge clk);
      chk("err_cleared", 32'(bus.err), 32'd0);
      err_m = 0;

      // Reset in the second RUN cycle of a len-5 run.
      set_counter(2);
      bus.req  = 2'b01;
      bus.len0 = 3'd5;
      repeat (3) @(negedge clk);
      chk("mid_T_before", 32'(T), 32'd1);
      bus.req = 2'b00;
      rst_n   = 1'b0;
      #1;
      chk("mid_rst_T", 32'(T), 32'd0);
      chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
      err_m = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_done", 32'(bus.done), 32'd0);
         chk("post_rst_busy", 32'(bus.busy), 32'd0);
      end

      // Randomised runs against the model.
      set_counter(int'($urandom_range(0, 7)));
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 1) == 1) set_counter(int'($urandom_range(0, 7)));
         run_one(2'($urandom_range(1, 3)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 1'b0, 1'b0, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
